// File: rtl/mema_row_loader.sv
// Serial-to-row loader for the systolic A-operand skew memory: gathers DIM
// elements per row, writes DIM rows, then runs the 2*DIM-1 cycle skew drain.
module mema_row_loader #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_AB-1:0] in_data,
    input  logic                      stall,
    output logic signed [BITS_AB-1:0] Ain [DIM-1:0],
    output logic [$clog2(DIM)-1:0]    Arow,
    output logic                      WrEn,
    output logic                      en,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(DIM);
    localparam int DW = $clog2(2 * DIM);
    localparam logic [CW-1:0] LAST_IDX   = CW'(DIM - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(2 * DIM - 2);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   col_cnt;
    logic [CW-1:0]   row_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        WrEn       = 1'b0;
        en         = 1'b0;
        done       = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && col_cnt == LAST_IDX) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                WrEn       = 1'b1;
                next_state = (row_cnt == LAST_IDX) ? DRAIN : FILL;
            end
            DRAIN: begin
                en = ~stall;
                if (!stall && drain_cnt == LAST_DRAIN) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = FILL;
            end
            default: next_state = FILL;
        endcase
    end

    // Idle means a fresh FILL with nothing of the current matrix taken yet.
    assign busy = !(state == FILL && col_cnt == '0 && row_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            Arow      <= '0;
            for (int i = 0; i < DIM; i++) begin
                Ain[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        Ain[col_cnt] <= in_data;
                        col_cnt      <= col_cnt + 1'b1;
                        if (col_cnt == LAST_IDX) begin
                            Arow <= row_cnt;
                        end
                    end
                end
                WRITE: begin
                    row_cnt <= row_cnt + 1'b1;
                end
                DRAIN: begin
                    if (en) begin
                        drain_cnt <= (drain_cnt == LAST_DRAIN) ? '0 : drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mema_row_loader.sv
// Scoreboard bench for mema_row_loader: stimulus queues expected rows and
// drain latencies, a negedge monitor checks them as the DUT presents them.
module tb_mema_row_loader;

    localparam int BITS = 8;
    localparam int DIM  = 8;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [BITS-1:0] in_data;
    logic                   stall;
    logic signed [BITS-1:0] Ain [DIM-1:0];
    logic [2:0]             Arow;
    logic                   WrEn;
    logic                   en;
    logic                   busy;
    logic                   done;

    mema_row_loader #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .stall    (stall),
        .Ain      (Ain),
        .Arow     (Arow),
        .WrEn     (WrEn),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [2:0]         row;
        logic [DIM*BITS-1:0] data;
    } row_exp_t;

    row_exp_t expQ[$];
    int       latQ[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;
    int       row7Cyc = 0;
    int       enCount = 0;
    int       doneCount = 0;
    bit       checkAfterDone = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic signed [BITS-1:0] elemVal(input int r, input int c, input bit neg);
        if (neg && r == 2 && c == 0) return -8'sd128;
        if (neg && r == 2 && c == 1) return -8'sd1;
        if (neg && r == 2 && c == 2) return 8'sd127;
        return BITS'(8 * r + c);
    endfunction

    function automatic logic [DIM*BITS-1:0] packAin();
        logic [DIM*BITS-1:0] f;
        for (int c = 0; c < DIM; c++) f[c*BITS +: BITS] = Ain[c];
        return f;
    endfunction

    // Monitor: everything is sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        row_exp_t e;
        cyc++;
        if (!rst) begin
            if (checkAfterDone) begin
                checkOutput("ready_after_done", {63'd0, in_ready}, 64'd1);
                checkOutput("busy_after_done", {63'd0, busy}, 64'd0);
                checkAfterDone = 0;
            end
            if (WrEn) begin
                checkOutput("wren_excl", {62'd0, in_ready, en}, 64'd0);
                if (expQ.size() == 0) begin
                    checkOutput("spurious_wren", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("arow", {61'd0, Arow}, {61'd0, e.row});
                    checkOutput("ain_row", packAin(), e.data);
                    if (e.row == 3'd7) row7Cyc = cyc;
                end
                enCount = 0;
            end
            if (en) enCount++;
            if (done) begin
                doneCount++;
                checkOutput("drain_en_count", 64'(enCount), 64'(2 * DIM - 1));
                if (latQ.size() == 0) begin
                    checkOutput("spurious_done", 64'd1, 64'd0);
                end else begin
                    checkOutput("done_latency", 64'(cyc - row7Cyc), 64'(latQ.pop_front()));
                end
                checkAfterDone = 1;
            end
        end
    end

    task automatic sendElem(input logic signed [BITS-1:0] v, input bit toggle);
        int guard = 0;
        if (toggle) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        do begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = v;
            guard++;
        end while (!in_ready && guard < 200);
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input bit toggle, input int nElems, input bit neg, input bit stallTest);
        row_exp_t e;
        for (int r = 0; r < DIM; r++) begin
            if ((r + 1) * DIM <= nElems) begin
                e.row = 3'(r);
                for (int c = 0; c < DIM; c++) e.data[c*BITS +: BITS] = elemVal(r, c, neg);
                expQ.push_back(e);
            end
        end
        if (nElems == DIM * DIM) latQ.push_back(stallTest ? 19 : 16);
        for (int i = 0; i < nElems; i++) sendElem(elemVal(i / DIM, i % DIM, neg), toggle);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (stallTest) begin
            repeat (3) begin @(posedge clk); #1; end
            stall = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            stall = 1'b0;
        end
    endtask

    task automatic waitDone(input int target);
        int g = 0;
        while (doneCount < target && g < 400) begin
            @(posedge clk);
            g++;
        end
        checkOutput("done_timeout", 64'(doneCount >= target), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ain"}, packAin(), 64'd0);
        checkOutput({tag, "_ctrl"}, {57'd0, Arow, WrEn, en, done, busy}, 64'd0);
        checkOutput({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset");

        // Held-valid matrix followed immediately by toggled, signed, stalled one.
        applyStimulus(1'b0, DIM * DIM, 1'b0, 1'b0);
        applyStimulus(1'b1, DIM * DIM, 1'b1, 1'b1);
        waitDone(2);

        applyStimulus(1'b0, 20, 1'b0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        latQ.delete();
        checkIdle("midreset");

        applyStimulus(1'b0, DIM * DIM, 1'b0, 1'b0);
        waitDone(3);
        checkOutput("queues_drained", 64'(expQ.size() + latQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
